// File: rtl/idli_sqi_ctrl.sv
// SQI serial-RAM transaction sequencer and FE/LS arbiter for the single SQI port.
// Optional feature macro IDLI_SQI_RR_ARB_EN: round-robin arbitration (default: fixed priority, LS over FE).
module idli_sqi_ctrl #(
    parameter logic [7:0]  CMD_RD  = 8'h03,
    parameter logic [7:0]  CMD_WR  = 8'h02,
    parameter int unsigned DUMMY_N = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fe_req,
    input  logic [15:0] i_fe_addr,
    output logic        o_fe_gnt,
    input  logic        i_ls_req,
    input  logic        i_ls_wr,
    input  logic [15:0] i_ls_addr,
    output logic        o_ls_gnt,
    output logic        o_owner,
    output logic        o_busy,
    input  logic        i_stop,
    output logic        o_rd_vld,
    output logic [3:0]  o_rd_slice,
    output logic        o_wr_rdy,
    input  logic [3:0]  i_wr_slice,
    output logic [1:0]  o_ctr,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio_out,
    output logic [3:0]  o_sqi_sio_oe,
    input  logic [3:0]  i_sqi_sio
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  ctr_q, ctr_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic        stop_pend_q, stop_pend_d;
    logic [3:0]  sio_q;
    logic        pick_ls;
    logic        busy;
    logic        data_st;
    logic [31:0] hdr_w;

`ifdef IDLI_SQI_RR_ARB_EN
    // prio_q=1 means LS wins the next tie; after each grant it points at the requester not served.
    logic prio_q, prio_d;
    assign pick_ls = i_ls_req & (~i_fe_req | prio_q);
    assign prio_d  = (state_q == ST_IDLE && (i_fe_req || i_ls_req)) ? ~pick_ls : prio_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) prio_q <= 1'b0;
        else          prio_q <= prio_d;
    end
`else
    assign pick_ls = i_ls_req;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            ctr_q       <= 2'd0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 16'd0;
            stop_pend_q <= 1'b0;
            sio_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctr_q       <= ctr_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            stop_pend_q <= stop_pend_d;
            sio_q       <= i_sqi_sio;
        end
    end

    // cnt_q runs 0..7 across CMD and ADDR so it doubles as the header nibble index.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctr_d       = ctr_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        stop_pend_d = stop_pend_q;
        o_fe_gnt    = 1'b0;
        o_ls_gnt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_fe_req || i_ls_req) begin
                    owner_d     = pick_ls;
                    wr_d        = pick_ls & i_ls_wr;
                    addr_d      = pick_ls ? i_ls_addr : i_fe_addr;
                    o_fe_gnt    = ~pick_ls;
                    o_ls_gnt    = pick_ls;
                    cnt_d       = 8'd0;
                    ctr_d       = 2'd0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_CMD;
                end
            end
            ST_CMD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd1) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd7) begin
                    cnt_d   = 8'd0;
                    state_d = wr_q ? ST_DATA : ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(DUMMY_N - 1)) state_d = ST_DATA;
            end
            ST_DATA: begin
                ctr_d = ctr_q + 2'd1;
                if (ctr_q == 2'd3) begin
                    if (i_stop || stop_pend_q) begin
                        stop_pend_d = 1'b0;
                        state_d     = ST_END;
                    end
                end else if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_DUMMY) || (state_q == ST_DATA);
    assign data_st = (state_q == ST_DATA);
    assign hdr_w   = {wr_q ? CMD_WR : CMD_RD, 7'b0, addr_q, 1'b0};

    always_comb begin
        o_busy        = busy;
        o_sqi_cs_n    = ~busy;
        o_sqi_sck_en  = busy;
        o_owner       = busy & owner_q;
        o_rd_vld      = data_st & ~wr_q;
        o_wr_rdy      = data_st & wr_q;
        o_rd_slice    = (data_st && !wr_q) ? sio_q : 4'h0;
        o_ctr         = data_st ? ctr_q : 2'd0;
        o_sqi_sio_out = 4'h0;
        o_sqi_sio_oe  = 4'h0;
        if (state_q == ST_CMD || state_q == ST_ADDR) begin
            o_sqi_sio_out = hdr_w[5'd31 - {cnt_q[2:0], 2'b00} -: 4];
            o_sqi_sio_oe  = 4'hF;
        end else if (data_st && wr_q) begin
            o_sqi_sio_out = i_wr_slice;
            o_sqi_sio_oe  = 4'hF;
        end
    end

endmodule
